// File: rtl/j_addp_pkg.sv
// ---------------------------------------------------------------------------
// j_addp_pkg
//   Shared definitions for the pipelined adder j_addp_pipe.
//   - j_addp_ctl_t : per-stage control record (valid, running carry, captured
//                    tap carry, captured msb-1 carry). The width-dependent part
//                    of a stage record (finished sum bits, pending a/b bits)
//                    sits beside it in the top as WIDTH-bit words.
//   - slice_width  : bits added per pipeline slice (WIDTH / STAGES).
//   - params_ok    : legality of a WIDTH / STAGES / TAP combination.
// ---------------------------------------------------------------------------
package j_addp_pkg;

  typedef struct packed {
    logic valid;   // beat present in this stage
    logic carry;   // carry out of the slice this stage finished
    logic tap;     // carry out of bit TAP-1, once that slice has been added
    logic msb1;    // carry out of bit WIDTH-2, once that slice has been added
  } j_addp_ctl_t;

  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  function automatic bit params_ok(input int unsigned width,
                                   input int unsigned stages,
                                   input int unsigned tap);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0) &&
           (tap >= 1) && (tap <= width - 1);
  endfunction

endpackage

// File: rtl/j_addp_slice.sv
// ---------------------------------------------------------------------------
// j_addp_slice
//   Combinational SW-bit ripple full-adder slice.
//   Ports:
//     a, b  in  SW  operand bits of this slice
//     ci    in  1   carry into bit 0 of the slice
//     s     out SW  slice sum
//     co    out 1   carry out of the top bit of the slice
//     cv    out SW  per-bit carry-out vector (cv[i] = carry out of bit i),
//                   used by the pipeline to pick off the tap / msb-1 carries
// ---------------------------------------------------------------------------
module j_addp_slice #(
  parameter int unsigned SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co,
  output logic [SW-1:0] cv
);

  always_comb begin
    logic cy;
    cy = ci;
    s  = '0;
    cv = '0;
    for (int i = 0; i < int'(SW); i++) begin
      s[i]  = a[i] ^ b[i] ^ cy;
      cy    = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
      cv[i] = cy;
    end
  end

  assign co = cv[SW-1];

endmodule

// File: rtl/j_addp_pipe.sv
// ---------------------------------------------------------------------------
// j_addp_pipe
//   Pipelined WIDTH-bit adder/subtractor. The carry chain is cut into STAGES
//   slices of WIDTH/STAGES bits; slice k is added in stage k, with the carry
//   registered between slices. Full-rate valid/ready streaming, latency
//   STAGES cycles.
//
//   Parameters: WIDTH (multiple of STAGES), STAGES (1..WIDTH),
//               TAP (1..WIDTH-1, bit whose carry-out is reported on co_tap).
//
//   Ports:
//     clk, resetl          clock, asynchronous active-low reset
//     in_valid / in_ready  operand beat handshake
//     a, b, c, sub         operands, carry in, subtract (b inverted on capture)
//     out_valid/out_ready  result beat handshake
//     s                    sum (modulo 2^WIDTH)
//     co, co_msb1, co_tap  carries out of bits WIDTH-1, WIDTH-2, TAP-1
//     ovf                  signed overflow (co ^ co_msb1)
//     sat                  saturation applied to this beat
//
//   Handshake: a beat moves from one place to the next on a cycle where the
//   sender is valid and the receiver is ready. A stage is ready when it is
//   empty or its own content moves on in the same cycle, so in_ready is a
//   combinational function of out_ready and the stage valids; with a full
//   pipe and out_ready=1 a beat is accepted and one emitted in the same cycle.
//   While out_valid & !out_ready the last stage holds, so outputs are stable.
//
//   Build option J_ADDP_SAT_EN: when defined, an overflowing result is
//   clamped to the signed extreme of its true sign and sat is raised; the
//   carry and ovf outputs still report the raw, unclamped values. When not
//   defined, s is the raw sum and sat is tied to 0.
// ---------------------------------------------------------------------------
module j_addp_pipe
  import j_addp_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4,
  parameter int unsigned TAP    = 24
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             co_msb1,
  output logic             co_tap,
  output logic             ovf,
  output logic             sat
);

  localparam int unsigned SW         = slice_width(WIDTH, STAGES);
  localparam int unsigned TAP_SLICE  = (TAP - 1) / SW;
  localparam int unsigned TAP_BIT    = (TAP - 1) % SW;
  localparam int unsigned MSB1_SLICE = (WIDTH - 2) / SW;
  localparam int unsigned MSB1_BIT   = (WIDTH - 2) % SW;

  if (!params_ok(WIDTH, STAGES, TAP)) begin : g_bad_params
    $error("j_addp_pipe: illegal WIDTH/STAGES/TAP combination");
  end

  // Stage registers. Sum bits are shifted in from the top so that after the
  // last slice every finished slice sits at its own bit position; pending
  // operand bits shift down so the next slice always reads bits [SW-1:0].
  j_addp_ctl_t      ctl_q [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];

  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_ready;
  logic [WIDTH-1:0]  b_eff;

  assign b_eff = b ^ {WIDTH{sub}};

  // Ready ripples back from out_ready through the stages.
  always_comb begin
    stage_ready = '0;
    stage_ready[STAGES-1] = !stage_valid[STAGES-1] | out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      stage_ready[k] = !stage_valid[k] | stage_ready[k+1];
    end
  end

  assign in_ready = stage_ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // One-hot picks of the slice carry vector; all-zero in slices that do
    // not own the tapped bit.
    localparam logic [SW-1:0] TAP_MASK  = (k == TAP_SLICE)  ? (SW'(1) << TAP_BIT)  : SW'(0);
    localparam logic [SW-1:0] MSB1_MASK = (k == MSB1_SLICE) ? (SW'(1) << MSB1_BIT) : SW'(0);

    logic             prev_v;
    logic             prev_ci;
    logic             prev_tap;
    logic             prev_msb1;
    logic [WIDTH-1:0] prev_sum;
    logic [WIDTH-1:0] prev_a;
    logic [WIDTH-1:0] prev_b;
    logic [SW-1:0]    sl_s;
    logic [SW-1:0]    sl_cv;
    logic             sl_co;

    if (k == 0) begin : g_first
      assign prev_v    = in_valid;
      assign prev_ci   = c;
      assign prev_tap  = 1'b0;
      assign prev_msb1 = 1'b0;
      assign prev_sum  = '0;
      assign prev_a    = a;
      assign prev_b    = b_eff;
    end else begin : g_chain
      assign prev_v    = ctl_q[k-1].valid;
      assign prev_ci   = ctl_q[k-1].carry;
      assign prev_tap  = ctl_q[k-1].tap;
      assign prev_msb1 = ctl_q[k-1].msb1;
      assign prev_sum  = sum_q[k-1];
      assign prev_a    = a_q[k-1];
      assign prev_b    = b_q[k-1];
    end

    j_addp_slice #(
      .SW (SW)
    ) u_slice (
      .a  (prev_a[SW-1:0]),
      .b  (prev_b[SW-1:0]),
      .ci (prev_ci),
      .s  (sl_s),
      .co (sl_co),
      .cv (sl_cv)
    );

    assign stage_valid[k] = ctl_q[k].valid;

    always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
        ctl_q[k] <= '0;
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end else if (stage_ready[k]) begin
        ctl_q[k].valid <= prev_v;
        if (prev_v) begin
          sum_q[k]       <= (prev_sum >> SW) | (WIDTH'(sl_s) << (WIDTH - SW));
          a_q[k]         <= prev_a >> SW;
          b_q[k]         <= prev_b >> SW;
          ctl_q[k].carry <= sl_co;
          // Earlier slices leave these 0; the owning slice sets them once
          // and later slices just carry them along with the beat.
          ctl_q[k].tap   <= prev_tap  | (|(sl_cv & TAP_MASK));
          ctl_q[k].msb1  <= prev_msb1 | (|(sl_cv & MSB1_MASK));
        end
      end
    end
  end

  logic [WIDTH-1:0] raw_s;

  assign raw_s     = sum_q[STAGES-1];
  assign out_valid = ctl_q[STAGES-1].valid;
  assign co        = ctl_q[STAGES-1].carry;
  assign co_msb1   = ctl_q[STAGES-1].msb1;
  assign co_tap    = ctl_q[STAGES-1].tap;
  assign ovf       = co ^ co_msb1;

`ifdef J_ADDP_SAT_EN
  // On overflow the raw sign bit is the wrong one: a set raw MSB means the
  // true result was positive, so clamp to 0111..1, otherwise to 1000..0.
  assign s   = ovf ? {~raw_s[WIDTH-1], {(WIDTH-1){raw_s[WIDTH-1]}}} : raw_s;
  assign sat = ovf;
`else
  assign s   = raw_s;
  assign sat = 1'b0;
`endif

endmodule

// File: tb/tb_j_addp_pipe.sv
// ---------------------------------------------------------------------------
// tb_j_addp_pipe
//   Directed vectors with hand-computed results, a 16-beat stream under a
//   stalling out_ready pattern, and a mid-flight reset. Expected results are
//   queued when a beat is accepted; a negedge monitor pops and compares
//   whenever a result beat is handed over.
// ---------------------------------------------------------------------------
module tb_j_addp_pipe;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 4;
  localparam int unsigned TAP    = 24;
  localparam int unsigned EW     = WIDTH + 5;

  logic             clk;
  logic             resetl;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             co_msb1;
  logic             co_tap;
  logic             ovf;
  logic             sat;

  j_addp_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .TAP    (TAP)
  ) dut (
    .clk       (clk),
    .resetl    (resetl),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .co_msb1   (co_msb1),
    .co_tap    (co_tap),
    .ovf       (ovf),
    .sat       (sat)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            tag_q[$];
  bit            lat_chk = 1'b0;
  bit            held_v  = 1'b0;
  logic [EW-1:0] held;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Packs {sat, ovf, co_tap, co_msb1, co, s} from raw adder results.
  function automatic logic [EW-1:0] expect_of(input logic [31:0] sr, input logic cof,
                                              input logic msb, input logic tap);
    logic        ov;
    logic [31:0] so;
    logic        st;
    ov = cof ^ msb;
    so = sr;
    st = 1'b0;
`ifdef J_ADDP_SAT_EN
    if (ov) begin
      so = sr[31] ? 32'h7FFF_FFFF : 32'h8000_0000;
      st = 1'b1;
    end
`endif
    return {st, ov, tap, msb, cof, so};
  endfunction

  // Reference for the random stream: plain wide additions on bit ranges.
  function automatic logic [EW-1:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mc, input logic msub);
    logic [31:0] bb;
    logic [32:0] full;
    logic [31:0] lo31;
    logic [24:0] lo24;
    bb   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + 33'(mc);
    lo31 = {1'b0, ma[30:0]} + {1'b0, bb[30:0]} + 32'(mc);
    lo24 = {1'b0, ma[23:0]} + {1'b0, bb[23:0]} + 25'(mc);
    return expect_of(full[31:0], full[32], lo31[31], lo24[24]);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] cur;
    logic [EW-1:0] e;
    int            acc;
    int            tg;
    cur = {sat, ovf, co_tap, co_msb1, co, s};
    if (!resetl) begin
      held_v = 1'b0;
    end else begin
      check_val("in_ready", 64'(in_ready),
                ((exp_q.size() == int'(STAGES)) && !out_ready) ? 64'd0 : 64'd1);
      if (held_v) begin
        check_val("hold_valid", 64'(out_valid), 64'd1);
        check_val("hold_data", 64'(cur), 64'(held));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h want no beat (cycle %0d)", cur, cyc);
        end else if (out_ready) begin
          e   = exp_q.pop_front();
          acc = acc_q.pop_front();
          tg  = tag_q.pop_front();
          check_val($sformatf("beat%0d", tg), 64'(cur), 64'(e));
          if (lat_chk) check_val($sformatf("latency%0d", tg), 64'(cyc - acc), 64'(STAGES));
        end
      end
      held_v = out_valid && !out_ready;
      held   = cur;
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a beat, waits for acceptance, queues its expected result, and
  // returns just after the accepting edge with in_valid still high.
  task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                      input logic vsub, input logic [EW-1:0] e, input int tg);
    int n;
    in_valid = 1'b1;
    a = va;
    b = vb;
    c = vc;
    sub = vsub;
    n = 0;
    forever begin
      @(negedge clk);
      #2;
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready=0 want 1 within 50 cycles (beat%0d)", tg);
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(e);
    acc_q.push_back(cyc);
    tag_q.push_back(tg);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_val("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        vc;
    logic        vsub;
    logic [31:0] rs;
    logic        rco;
    logic        rmsb1;
    logic        rtap;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1};
  end

  // ---------------- main sequence ----------------
  bit stream_done = 1'b0;
  bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    resetl    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    c = 1'b0;
    sub = 1'b0;
    #1;
    check_val("reset_outputs", 64'({out_valid, sat, ovf, co_tap, co_msb1, co, s}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    resetl = 1'b1;
    #1;
    check_val("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors, back to back, no stalls: fixed latency.
    lat_chk = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].vsub,
           expect_of(vecs[i].rs, vecs[i].rco, vecs[i].rmsb1, vecs[i].rtap), i);
    end
    drain();
    lat_chk = 1'b0;

    // Stream of 16 random beats with out_ready cycling 1,0,0,1,1,0.
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          logic [31:0] ra;
          logic [31:0] rb;
          logic        rc;
          logic        rsub;
          ra   = $urandom;
          rb   = $urandom;
          rc   = 1'($urandom_range(0, 1));
          rsub = 1'($urandom_range(0, 1));
          send(ra, rb, rc, rsub, model(ra, rb, rc, rsub), 100 + i);
        end
        in_valid = 1'b0;
        stream_done = 1'b1;
      end
      begin
        int p;
        p = 0;
        while (!stream_done) begin
          out_ready = pat[p];
          @(posedge clk);
          #1;
          p = (p + 1) % 6;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with three beats in flight, the oldest already held at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].vsub,
           expect_of(vecs[i].rs, vecs[i].rco, vecs[i].rmsb1, vecs[i].rtap), 200 + i);
    end
    idle(2);
    check_val("pre_reset_valid", 64'(out_valid), 64'd1);
    #2;
    exp_q.delete();
    acc_q.delete();
    tag_q.delete();
    resetl = 1'b0;
    #1;
    check_val("reset_mid_valid", 64'(out_valid), 64'd0);
    check_val("reset_mid_sum", 64'(s), 64'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetl = 1'b1;
    idle(8);
    check_val("post_reset_idle", 64'(out_valid), 64'd0);
    send(vecs[4].va, vecs[4].vb, vecs[4].vc, vecs[4].vsub,
         expect_of(vecs[4].rs, vecs[4].rco, vecs[4].rmsb1, vecs[4].rtap), 300);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    checks++;
    errors++;
    $display("FAIL watchdog: got timeout want completion (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
